// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction prefetch stage.
//   ifu_state_e : fetch FSM state (IDLE, WAIT, DROP)
//   ifu_entry_t : prefetch queue entry {pc, instr, err}
//   IFU_PC_STEP : byte increment between sequential fetches
package ifu_pkg;

    localparam int unsigned IFU_ADDR_W  = 32;
    localparam int unsigned IFU_DATA_W  = 32;
    localparam int unsigned IFU_PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] instr;
        logic                  err;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: show-ahead synchronous FIFO of ifu_entry_t for the prefetch queue.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (storage cleared too)
//   flush_i       : synchronous flush, overrides push and pop on the same edge
//   push_i/wdata_i: write one entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : current head entry (show-ahead)
//   count_o       : number of valid entries
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  ifu_entry_t      wdata_i,
    input  logic            pop_i,
    output ifu_entry_t      rdata_o,
    output logic [CntW-1:0] count_o
);

    ifu_entry_t      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign do_push = push_i && (count_q != CntW'(Depth)) && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (do_push && !do_pop) begin
                count_d = count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher in front of the MMU read port.
// Keeps one read outstanding, buffers returned words with their PCs in ifu_fifo
// and hands them to decode over a valid/ready handshake. A redirect flushes the
// queue, restarts fetching at redirect_pc and discards any in-flight response.
//
// Optional build macro IFU_PREFETCH_ALIGN_CHECK_EN: a redirect to a non
// word-aligned PC queues one error entry and halts fetching until the next
// redirect. Without it, redirect_pc[1:0] is ignored and o_err is always 0.
//
// Ports:
//   ifu_clk, i_rstn    : clock, asynchronous active-low reset
//   rd_req, rd_addr    : MMU request pulse and fetch address (held until response)
//   rd_data, rd_valid  : MMU response
//   redirect_valid/_pc : flush and restart request from branch/exception logic
//   o_valid, o_pc, o_instr, o_err, i_ready : queue head towards decode
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              ifu_clk,
    input  logic              i_rstn,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_err,
    input  logic              i_ready
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              fetch_ok;
    logic              head_valid;

    logic              fifo_push;
    logic              fifo_pop;
    ifu_entry_t        fifo_wdata;
    ifu_entry_t        fifo_head;
    logic [CntW-1:0]   fifo_count;

`ifdef IFU_PREFETCH_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] PcReset = RESET_PC;

    logic              halt_q, halt_d;
    logic              err_pend_q, err_pend_d;
    logic [ADDR_W-1:0] err_pc_q, err_pc_d;
    logic              misaligned;

    assign misaligned   = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
    assign fetch_ok     = (fifo_count < CntW'(DEPTH)) && !halt_q;

    // The error entry is queued one edge after the redirect, because the
    // redirect edge itself flushes the queue.
    always_comb begin
        halt_d     = halt_q;
        err_pend_d = 1'b0;
        err_pc_d   = err_pc_q;
        if (redirect_valid) begin
            halt_d     = misaligned;
            err_pend_d = misaligned;
            err_pc_d   = redirect_pc;
        end
    end

    always_ff @(posedge ifu_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            halt_q     <= 1'b0;
            err_pend_q <= 1'b0;
            err_pc_q   <= '0;
        end else begin
            halt_q     <= halt_d;
            err_pend_q <= err_pend_d;
            err_pc_q   <= err_pc_d;
        end
    end

    assign o_err = fifo_head.err;
`else
    localparam logic [ADDR_W-1:0] PcReset = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic unused_align_bits;

    assign unused_align_bits = ^{redirect_pc[1:0], fifo_head.err};
    assign redirect_tgt      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign fetch_ok          = (fifo_count < CntW'(DEPTH));
    assign o_err             = 1'b0;
`endif

    assign head_valid = (fifo_count != '0);
    assign fifo_pop   = head_valid && i_ready;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        rd_req_d         = 1'b0;
        rd_addr_d        = rd_addr_q;
        fifo_push        = 1'b0;
        fifo_wdata.pc    = rd_addr_q;
        fifo_wdata.instr = rd_data;
        fifo_wdata.err   = 1'b0;

        if (redirect_valid) begin
            // No request on a redirect edge; an outstanding read must still
            // be absorbed, so WAIT/DROP only return to IDLE with rd_valid.
            pc_d = redirect_tgt;
            unique case (state_q)
                WAIT, DROP: state_d = rd_valid ? IDLE : DROP;
                default:    state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_ok) begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = pc_q;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (rd_valid) begin
                        fifo_push = 1'b1;
                        pc_d      = pc_q + ADDR_W'(IFU_PC_STEP);
                        state_d   = IDLE;
                    end
                end
                DROP: begin
                    if (rd_valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef IFU_PREFETCH_ALIGN_CHECK_EN
        // Halted in IDLE or discarding in DROP here, so no response push clashes.
        if (err_pend_q) begin
            fifo_push        = 1'b1;
            fifo_wdata.pc    = err_pc_q;
            fifo_wdata.instr = '0;
            fifo_wdata.err   = 1'b1;
        end
`endif
    end

    always_ff @(posedge ifu_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            pc_q      <= PcReset;
            rd_req_q  <= 1'b0;
            rd_addr_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    ifu_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (ifu_clk),
        .rst_ni  (i_rstn),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign o_valid = head_valid;
    assign o_pc    = fifo_head.pc;
    assign o_instr = fifo_head.instr;

endmodule
